gobang_game_ctrl: RTL

// Game sequencer for the gobang board: turns decoded PS/2 key events into cursor moves,

---
 rtl/gobang_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gobang_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gobang_game_ctrl
// Purpose  : Gobang game sequencer. Turns decoded PS/2 make codes into cursor
//            moves, stone placement and restarts. Owns the write port and
//            the controller read port of the dual-port board RAM. After every
//            legal placement it scans the four lines through the new stone
//            and stops the game on five (or more) in a row.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   key_valid, key_code  1-cycle strobe with a PS/2 set-2 make code
//   cursor_x, cursor_y   cursor cell
//   cur_player           side to move (0 black, 1 white)
//   busy                 clearing, checking, writing or scanning
//   game_over, winner    game finished / colour of the winner
//   we, waddr, wdata     board write port (00 empty, 01 black, 10 white)
//   raddr, rdata         board read port, rdata valid one cycle after raddr
// ============================================================================
module gobang_game_ctrl #(
  parameter int N      = 15,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [3:0]        cursor_x,
  output logic [3:0]        cursor_y,
  output logic              cur_player,
  output logic              busy,
  output logic              game_over,
  output logic              winner,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [1:0]        wdata,
  output logic [ADDR_W-1:0] raddr,
  input  logic [1:0]        rdata
);

  localparam logic [7:0] KEY_UP      = 8'h1D;
  localparam logic [7:0] KEY_DOWN    = 8'h1B;
  localparam logic [7:0] KEY_LEFT    = 8'h1C;
  localparam logic [7:0] KEY_RIGHT   = 8'h23;
  localparam logic [7:0] KEY_PLACE   = 8'h29;
  localparam logic [7:0] KEY_RESTART = 8'h2D;
  localparam logic [3:0] MAX_C       = 4'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

  typedef enum logic [3:0] {
    S_CLEAR    = 4'd0,
    S_IDLE     = 4'd1,
    S_RD       = 4'd2,
    S_CHK      = 4'd3,
    S_WR       = 4'd4,
    S_SCAN_ISS = 4'd5,
    S_SCAN_RD  = 4'd6,
    S_SCAN_CK  = 4'd7,
    S_OVER     = 4'd8
  } state_t;

  state_t state, state_n;

  logic [3:0]        cursor_x_n, cursor_y_n, px, py, px_n, py_n;
  logic              cur_player_n, winner_n, we_n, side, side_n;
  logic [ADDR_W-1:0] waddr_n, raddr_n, clr_addr, clr_addr_n;
  logic [1:0]        wdata_n, dir, dir_n, own;
  logic [2:0]        k, k_n, step_k;
  logic [3:0]        cnt, cnt_n;

  logic signed [5:0] step_dx, step_dy, cand_x, cand_y;
  logic              cand_ok;
  logic [ADDR_W-1:0] cand_addr;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] x, input logic [3:0] y);
    return ADDR_W'(y) * ADDR_W'(N) + ADDR_W'(x);
  endfunction

  assign own       = cur_player ? 2'b10 : 2'b01;
  assign busy      = (state != S_IDLE) && (state != S_OVER);
  assign game_over = (state == S_OVER);

  // Candidate cell P + k*d for the current direction and side. While checking
  // a read result the next step (k+1) is prepared so a matching run issues
  // one read every two cycles. k = 5 marks a finished side. The board-edge
  // test is done on sign-extended coordinates, never on the linear address.
  always_comb begin
    step_k  = (state == S_SCAN_CK) ? k + 3'd1 : k;
    step_dx = (dir == 2'd1) ? 6'sd0 : 6'sd1;
    case (dir)
      2'd0:    step_dy = 6'sd0;
      2'd3:    step_dy = -6'sd1;
      default: step_dy = 6'sd1;
    endcase
    if (side) begin
      step_dx = -step_dx;
      step_dy = -step_dy;
    end
    cand_x    = $signed({2'b00, px}) + step_dx * $signed({3'b000, step_k});
    cand_y    = $signed({2'b00, py}) + step_dy * $signed({3'b000, step_k});
    cand_ok   = (step_k >= 3'd1) && (step_k <= 3'd4) &&
                (cand_x >= 6'sd0) && (cand_x <= $signed({2'b00, MAX_C})) &&
                (cand_y >= 6'sd0) && (cand_y <= $signed({2'b00, MAX_C}));
    cand_addr = addr_of(cand_x[3:0], cand_y[3:0]);
  end

  always_comb begin
    state_n      = state;
    cursor_x_n   = cursor_x;
    cursor_y_n   = cursor_y;
    cur_player_n = cur_player;
    winner_n     = winner;
    we_n         = 1'b0;
    waddr_n      = waddr;
    wdata_n      = wdata;
    raddr_n      = raddr;
    px_n         = px;
    py_n         = py;
    clr_addr_n   = clr_addr;
    dir_n        = dir;
    side_n       = side;
    k_n          = k;
    cnt_n        = cnt;
    case (state)
      S_CLEAR: begin
        we_n       = 1'b1;
        waddr_n    = clr_addr;
        wdata_n    = 2'b00;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_n      = S_IDLE;
          cur_player_n = 1'b0;
        end
      end
      S_IDLE: begin
        if (key_valid) begin
          case (key_code)
            KEY_UP:    if (cursor_y != 4'd0)  cursor_y_n = cursor_y - 4'd1;
            KEY_DOWN:  if (cursor_y != MAX_C) cursor_y_n = cursor_y + 4'd1;
            KEY_LEFT:  if (cursor_x != 4'd0)  cursor_x_n = cursor_x - 4'd1;
            KEY_RIGHT: if (cursor_x != MAX_C) cursor_x_n = cursor_x + 4'd1;
            KEY_PLACE: begin
              px_n    = cursor_x;
              py_n    = cursor_y;
              raddr_n = addr_of(cursor_x, cursor_y);
              state_n = S_RD;
            end
            KEY_RESTART: begin
              clr_addr_n = '0;
              state_n    = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_RD: state_n = S_CHK;
      S_CHK: begin
        if (rdata != 2'b00) begin
          state_n = S_IDLE;
        end else begin
          we_n    = 1'b1;
          waddr_n = addr_of(px, py);
          wdata_n = own;
          state_n = S_WR;
        end
      end
      S_WR: begin
        dir_n   = 2'd0;
        side_n  = 1'b0;
        k_n     = 3'd1;
        cnt_n   = 4'd0;
        state_n = S_SCAN_ISS;
      end
      S_SCAN_ISS: begin
        if (cand_ok) begin
          raddr_n = cand_addr;
          state_n = S_SCAN_RD;
        end else if (!side) begin
          side_n = 1'b1;
          k_n    = 3'd1;
        end else if (cnt >= 4'd4) begin
          // run = 1 + matches on both sides
          winner_n = cur_player;
          state_n  = S_OVER;
        end else if (dir == 2'd3) begin
          cur_player_n = ~cur_player;
          state_n      = S_IDLE;
        end else begin
          dir_n  = dir + 2'd1;
          side_n = 1'b0;
          k_n    = 3'd1;
          cnt_n  = 4'd0;
        end
      end
      S_SCAN_RD: state_n = S_SCAN_CK;
      S_SCAN_CK: begin
        if (rdata == own) begin
          cnt_n = cnt + 4'd1;
          if (cand_ok) begin
            raddr_n = cand_addr;
            k_n     = k + 3'd1;
            state_n = S_SCAN_RD;
          end else begin
            k_n     = 3'd5;
            state_n = S_SCAN_ISS;
          end
        end else begin
          k_n     = 3'd5;
          state_n = S_SCAN_ISS;
        end
      end
      S_OVER: begin
        if (key_valid && (key_code == KEY_RESTART)) begin
          clr_addr_n = '0;
          state_n    = S_CLEAR;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_x   <= 4'd7;
      cursor_y   <= 4'd7;
      cur_player <= 1'b0;
      winner     <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= 2'b00;
      raddr      <= '0;
      px         <= 4'd0;
      py         <= 4'd0;
      clr_addr   <= '0;
      dir        <= 2'd0;
      side       <= 1'b0;
      k          <= 3'd1;
      cnt        <= 4'd0;
    end else begin
      cursor_x   <= cursor_x_n;
      cursor_y   <= cursor_y_n;
      cur_player <= cur_player_n;
      winner     <= winner_n;
      we         <= we_n;
      waddr      <= waddr_n;
      wdata      <= wdata_n;
      raddr      <= raddr_n;
      px         <= px_n;
      py         <= py_n;
      clr_addr   <= clr_addr_n;
      dir        <= dir_n;
      side       <= side_n;
      k          <= k_n;
      cnt        <= cnt_n;
    end
  end

endmodule
`default_nettype wire
